// File: rtl/video_timing.sv
`default_nettype none
// =====================================================================
// Module   : video_timing
// Purpose  : Raster x/y generator with sync/DE decode, latency-matched
//            delay line and blanked, registered RGB output stage.
// Revision : 1.0  initial release
// =====================================================================
module video_timing #(
   parameter int H_ACTIVE   = 768,
   parameter int H_FP       = 24,
   parameter int H_SYNC     = 80,
   parameter int H_BP       = 104,
   parameter int V_ACTIVE   = 576,
   parameter int V_FP       = 3,
   parameter int V_SYNC     = 7,
   parameter int V_BP       = 17,
   parameter bit HS_POL     = 1'b0,
   parameter bit VS_POL     = 1'b1,
   parameter int PIPE_DELAY = 1
) (
   input  logic        clk,
   input  logic        resetn,
   output logic [10:0] x,
   output logic [9:0]  y,
   input  logic [7:0]  r_in,
   input  logic [7:0]  g_in,
   input  logic [7:0]  b_in,
   output logic [7:0]  r_out,
   output logic [7:0]  g_out,
   output logic [7:0]  b_out,
   output logic        hsync_out,
   output logic        vsync_out,
   output logic        de_out,
   output logic        frame_start
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   generate
      if (H_TOTAL > 2048 || V_TOTAL > 1024 || PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_param_check
         $error("video_timing: illegal timing parameters");
      end
   endgenerate

   // Decode bounds are one bit wider than the counters so an end bound equal to the total still fits.
   localparam logic [10:0] X_LAST   = 11'(H_TOTAL - 1);
   localparam logic [9:0]  Y_LAST   = 10'(V_TOTAL - 1);
   localparam logic [11:0] X_ACT    = 12'(H_ACTIVE);
   localparam logic [11:0] HS_START = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] Y_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);

   logic [10:0]           x_q, x_d;
   logic [9:0]            y_q, y_d;
   logic                  frame_start_q, frame_start_d;
   logic                  x_wrap;
   logic [11:0]           x_ext;
   logic [10:0]           y_ext;
   logic                  de_raw, hs_raw, vs_raw;
   logic [PIPE_DELAY-1:0] de_sr_q, de_sr_d;
   logic [PIPE_DELAY-1:0] hs_sr_q, hs_sr_d;
   logic [PIPE_DELAY-1:0] vs_sr_q, vs_sr_d;
   logic                  de_d, hs_d, vs_d;
   logic [7:0]            r_out_q, r_out_d;
   logic [7:0]            g_out_q, g_out_d;
   logic [7:0]            b_out_q, b_out_d;
   logic                  hsync_q, hsync_d;
   logic                  vsync_q, vsync_d;
   logic                  de_out_q, de_out_d;

   // Raster counters; frame_start is precomputed from the next position.
   always_comb begin
      x_wrap        = (x_q == X_LAST);
      x_d           = x_wrap ? 11'd0 : x_q + 11'd1;
      y_d           = y_q;
      if (x_wrap) begin
         y_d = (y_q == Y_LAST) ? 10'd0 : y_q + 10'd1;
      end
      frame_start_d = (x_d == 11'd0) && (y_d == 10'd0);
   end

   always_comb begin
      x_ext  = {1'b0, x_q};
      y_ext  = {1'b0, y_q};
      de_raw = (x_ext < X_ACT) && (y_ext < Y_ACT);
      hs_raw = (x_ext >= HS_START) && (x_ext < HS_END);
      vs_raw = (y_ext >= VS_START) && (y_ext < VS_END);
   end

   always_comb begin
      de_sr_d    = de_sr_q;
      hs_sr_d    = hs_sr_q;
      vs_sr_d    = vs_sr_q;
      de_sr_d[0] = de_raw;
      hs_sr_d[0] = hs_raw;
      vs_sr_d[0] = vs_raw;
      for (int i = 1; i < PIPE_DELAY; i++) begin
         de_sr_d[i] = de_sr_q[i-1];
         hs_sr_d[i] = hs_sr_q[i-1];
         vs_sr_d[i] = vs_sr_q[i-1];
      end
   end

   assign de_d = de_sr_q[PIPE_DELAY-1];
   assign hs_d = hs_sr_q[PIPE_DELAY-1];
   assign vs_d = vs_sr_q[PIPE_DELAY-1];

   always_comb begin
      de_out_d = de_d;
      r_out_d  = de_d ? r_in : 8'h00;
      g_out_d  = de_d ? g_in : 8'h00;
      b_out_d  = de_d ? b_in : 8'h00;
      hsync_d  = hs_d ? HS_POL : ~HS_POL;
      vsync_d  = vs_d ? VS_POL : ~VS_POL;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         x_q           <= 11'd0;
         y_q           <= 10'd0;
         frame_start_q <= 1'b0;
         de_sr_q       <= '0;
         hs_sr_q       <= '0;
         vs_sr_q       <= '0;
         de_out_q      <= 1'b0;
         r_out_q       <= 8'h00;
         g_out_q       <= 8'h00;
         b_out_q       <= 8'h00;
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
      end else begin
         x_q           <= x_d;
         y_q           <= y_d;
         frame_start_q <= frame_start_d;
         de_sr_q       <= de_sr_d;
         hs_sr_q       <= hs_sr_d;
         vs_sr_q       <= vs_sr_d;
         de_out_q      <= de_out_d;
         r_out_q       <= r_out_d;
         g_out_q       <= g_out_d;
         b_out_q       <= b_out_d;
         hsync_q       <= hsync_d;
         vsync_q       <= vsync_d;
      end
   end

   assign x           = x_q;
   assign y           = y_q;
   assign frame_start = frame_start_q;
   assign de_out      = de_out_q;
   assign r_out       = r_out_q;
   assign g_out       = g_out_q;
   assign b_out       = b_out_q;
   assign hsync_out   = hsync_q;
   assign vsync_out   = vsync_q;

endmodule
`default_nettype wire
